// File: rtl/gng_stats_monitor.sv
// Windowed statistics (sum, sum of squares, min, max) over Gaussian noise sample pairs.
// Define GNG_STATS_HIST_EN to add an 8-bin histogram of sample[15:13] read through hist_sel/hist_cnt.
module gng_stats_monitor #(
  parameter int WINDOW_LOG2 = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic signed [15:0] x0,
  input  logic signed [15:0] x1,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic signed [47:0] sum_out,
  output logic        [63:0] sq_out,
  output logic signed [15:0] min_out,
  output logic signed [15:0] max_out,
  input  logic        [2:0]  hist_sel,
  output logic        [17:0] hist_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [WINDOW_LOG2-1:0]   cnt_q;
  logic signed [47:0]       sum_acc_q, sum_nxt;
  logic        [63:0]       sq_acc_q, sq_nxt;
  logic signed [15:0]       min_acc_q, max_acc_q, min_nxt, max_nxt;
  logic signed [47:0]       sum_res_q;
  logic        [63:0]       sq_res_q;
  logic signed [15:0]       min_res_q, max_res_q;
  logic signed [31:0]       x0_w, x1_w, sq0, sq1;
  logic                     acc_en, last;

  function automatic logic signed [15:0] smin(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // A start pulse always wins over the sample presented with it.
  assign acc_en = (state_q == S_ACCUM) && in_valid && !start;
  assign last   = acc_en && (&cnt_q);

  always_comb begin
    x0_w    = 32'(x0);
    x1_w    = 32'(x1);
    sq0     = x0_w * x0_w;
    sq1     = x1_w * x1_w;
    sum_nxt = sum_acc_q + 48'(x0) + 48'(x1);
    sq_nxt  = sq_acc_q + 64'($unsigned(sq0)) + 64'($unsigned(sq1));
    min_nxt = smin(min_acc_q, smin(x0, x1));
    max_nxt = smax(max_acc_q, smax(x0, x1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (start) state_d = S_ACCUM;
               else if (last) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_ACCUM;
               else if (ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sum_acc_q <= '0;
      sq_acc_q  <= '0;
      min_acc_q <= '0;
      max_acc_q <= '0;
      sum_res_q <= '0;
      sq_res_q  <= '0;
      min_res_q <= '0;
      max_res_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q     <= '0;
        sum_acc_q <= '0;
        sq_acc_q  <= '0;
        min_acc_q <= 16'sh7FFF;
        max_acc_q <= 16'sh8000;
      end else if (acc_en) begin
        cnt_q     <= cnt_q + 1'b1;
        sum_acc_q <= sum_nxt;
        sq_acc_q  <= sq_nxt;
        min_acc_q <= min_nxt;
        max_acc_q <= max_nxt;
        // Results capture the window including its final pair, then stay frozen.
        if (last) begin
          sum_res_q <= sum_nxt;
          sq_res_q  <= sq_nxt;
          min_res_q <= min_nxt;
          max_res_q <= max_nxt;
        end
      end
    end
  end

  assign busy    = (state_q == S_ACCUM);
  assign done    = (state_q == S_DONE);
  assign sum_out = sum_res_q;
  assign sq_out  = sq_res_q;
  assign min_out = min_res_q;
  assign max_out = max_res_q;

`ifdef GNG_STATS_HIST_EN
  logic [17:0] bins_q     [8];
  logic [17:0] bins_d     [8];
  logic [17:0] res_bins_q [8];
  logic [17:0] hist_cnt_q;

  always_comb begin
    for (int b = 0; b < 8; b++) begin
      bins_d[b] = bins_q[b] + 18'(x0[15:13] == 3'(b)) + 18'(x1[15:13] == 3'(b));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < 8; b++) begin
        bins_q[b]     <= '0;
        res_bins_q[b] <= '0;
      end
      hist_cnt_q <= '0;
    end else begin
      if (start) begin
        for (int b = 0; b < 8; b++) bins_q[b] <= '0;
      end else if (acc_en) begin
        for (int b = 0; b < 8; b++) bins_q[b] <= bins_d[b];
        if (last) begin
          for (int b = 0; b < 8; b++) res_bins_q[b] <= bins_d[b];
        end
      end
      hist_cnt_q <= res_bins_q[hist_sel];
    end
  end

  assign hist_cnt = hist_cnt_q;
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^hist_sel;
  assign hist_cnt        = '0;
`endif

endmodule

// File: doc/gng_stats_monitor.md
GNG_STATS_MONITOR -- requirements
Module: gng_stats_monitor

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 10, log2 of sample pairs per measurement window (legal 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins (or restarts) a window.
REQ-005 SHALL have port in_valid  input  1  x0/x1 carry a valid sample pair this cycle.
REQ-006 SHALL have ports x0, x1  input  16 each  signed two's-complement noise samples from the generator.
REQ-007 SHALL have port ack  input  1  consumer acknowledges results; clears done.
REQ-008 SHALL have port busy  output  1  high while a window is accumulating.
REQ-009 SHALL have port done  output  1  results valid, held until ack or start.
REQ-010 SHALL have port sum_out  output  48  signed sum of all 2*2^WINDOW_LOG2 samples, sign-extended.
REQ-011 SHALL have port sq_out  output  64  unsigned sum of squares of all samples, zero-extended.
REQ-012 SHALL have ports min_out, max_out  output  16 each  signed minimum/maximum sample in window.
REQ-013 SHALL have ports hist_sel  input  3, hist_cnt  output  18  histogram bin select and its count.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE; busy=1 only in ACCUM, done=1 only in DONE.
REQ-015 IDLE: start -> ACCUM next cycle; in_valid ignored.
REQ-016 Entering ACCUM SHALL clear pair counter, sum, sum-of-squares accumulators; internal min preset 16'h7FFF, max preset 16'h8000.
REQ-017 Sample present in the same cycle as start SHALL be ignored; accumulation begins the following cycle.
REQ-018 ACCUM: each in_valid cycle SHALL add x0+x1 to sum, x0*x0+x1*x1 to sum-of-squares, update min/max over both samples, increment pair counter; in_valid=0 cycles change nothing.
REQ-019 On the in_valid cycle that makes pair count 2^WINDOW_LOG2, SHALL transition to DONE; outputs and done valid the next cycle (latency 1 after final sample).
REQ-020 Accumulators SHALL be wide enough never to overflow at WINDOW_LOG2=16 (sum >= 33 bits, squares >= 49 bits).
REQ-021 start in ACCUM SHALL discard the partial window and restart (REQ-016) without passing through IDLE.
REQ-022 DONE: ack -> IDLE, done drops next cycle, result outputs retain values; start -> ACCUM directly; start and ack together: start wins.
REQ-023 Result outputs SHALL change only on entry to DONE; unchanged during a subsequent ACCUM.
REQ-024 ack outside DONE SHALL be ignored.

Reset
REQ-025 reset=0 at a clock edge SHALL force IDLE regardless of state, including mid-window.
REQ-026 After reset: busy=0, done=0, sum_out=0, sq_out=0, min_out=0, max_out=0, hist_cnt=0, all histogram bins 0.

Configuration
REQ-027 Macro GNG_STATS_HIST_EN SHALL compile in an 8-bin histogram.
REQ-028 With GNG_STATS_HIST_EN: bin index = sample[15:13]; each valid ACCUM cycle increments bin of x0 and bin of x1 (same bin -> +2); bins cleared on ACCUM entry; hist_cnt registered, = bin[hist_sel] one cycle after hist_sel, frozen-result semantics as REQ-023.
REQ-029 Without GNG_STATS_HIST_EN: no histogram storage; hist_cnt tied 0; hist_sel ignored.

Verification
REQ-030 WINDOW_LOG2=2; start; 4 valid cycles x0=16'h0001, x1=16'hFFFF -> done next cycle after 4th, sum_out=0, sq_out=8, min_out=16'hFFFF, max_out=16'h0001.
REQ-031 WINDOW_LOG2=2; valid on alternate cycles with x0=x1=16'h0003 -> only valid cycles counted; done after 4th valid; sum_out=24, sq_out=72.
REQ-032 Reset low after 2 of 4 samples -> next cycle busy=0, done=0, all outputs 0; new start yields full window unaffected by old samples.
REQ-033 start after 3 of 4 samples, then 4 samples x0=x1=16'h0002 -> sum_out=16, sq_out=32 (old partial discarded); start-cycle sample excluded.
REQ-034 DONE with ack and start same cycle -> busy=1 next cycle, previous results still visible until new window completes.
REQ-035 GNG_STATS_HIST_EN, WINDOW_LOG2=2, 4 cycles x0=x1=16'h2000 -> hist_sel=1 gives hist_cnt=8, other bins 0; without macro hist_cnt=0.
